xreg_sb: RTL and testbench

//  Parametrised multi-port integer register file with an integrated scoreboard.
//  Two write ports: A is ALU writeback, B is late load writeback. NUM_RD combinational read ports with same-cycle write bypass.
//  Per-register busy bits track pending producers for the decode stage's hazard logic.
//  A sequential clear engine zeroes the whole file on request, e.g. on core reset-vector restart or debug flush.

---
 rtl/xreg_sb.sv | 178 +++++++++++++++++
 tb/tb_xreg_sb.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xreg_sb.sv
// -----------------------------------------------------------------------------
// xreg_sb : multi-port integer register file with an integrated scoreboard
//
// Purpose
//   Holds NUM_REGS = 2**ADDR_W registers of DATA_W bits. x0 is hard-wired to
//   zero. There are two write ports: A is ALU writeback and B is late load
//   writeback; B wins when both hit the same index. NUM_RD combinational read
//   ports forward same-cycle writes. One busy bit per register records a
//   pending producer for the decode stage's hazard logic. A clear engine
//   zeroes the file one register per cycle on request.
//
// Ports
//   clk_i        core clock, all state updates on posedge
//   rst_n_i      asynchronous active-low reset
//   rd_addr_i    packed read indices, port k = [k*ADDR_W +: ADDR_W]
//   rd_data_o    packed read data, port k = [k*DATA_W +: DATA_W]
//   rd_busy_o    per read port: addressed register has a pending producer
//   wa_vld_i / wa_addr_i / wa_data_i   write port A
//   wb_vld_i / wb_addr_i / wb_data_i   write port B (priority over A)
//   iss_vld_i / iss_addr_i             issue: mark destination busy
//   clr_req_i    start clear sequence (level, sampled only in IDLE)
//   clr_busy_o   clear sequence in progress
// -----------------------------------------------------------------------------
module xreg_sb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr_i,
  output logic [NUM_RD*DATA_W-1:0]   rd_data_o,
  output logic [NUM_RD-1:0]          rd_busy_o,
  input  logic                       wa_vld_i,
  input  logic [ADDR_W-1:0]          wa_addr_i,
  input  logic [DATA_W-1:0]          wa_data_i,
  input  logic                       wb_vld_i,
  input  logic [ADDR_W-1:0]          wb_addr_i,
  input  logic [DATA_W-1:0]          wb_data_i,
  input  logic                       iss_vld_i,
  input  logic [ADDR_W-1:0]          iss_addr_i,
  input  logic                       clr_req_i,
  output logic                       clr_busy_o
);

  localparam int NUM_REGS = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);
  localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  logic [0:0]        state_reg;
  logic [ADDR_W-1:0] ptr_reg;
  logic              idle;

  // Qualified write/issue strobes. Everything is gated by IDLE so the clear
  // engine owns the array exclusively, and x0 traffic is dropped here once
  // rather than in every per-register slice.
  logic wa_en;
  logic wb_en;
  logic iss_en;
  logic clr_start;

  assign idle      = (state_reg == ST_IDLE);
  assign wa_en     = idle & wa_vld_i  & (wa_addr_i  != '0);
  assign wb_en     = idle & wb_vld_i  & (wb_addr_i  != '0);
  assign iss_en    = idle & iss_vld_i & (iss_addr_i != '0);
  assign clr_start = idle & clr_req_i;
  assign clr_busy_o = ~idle;

  // ---------------------------------------------------------------------------
  // Clear FSM: the entry edge preloads ptr=1 (x0 needs no clearing), then one
  // register is zeroed per edge; the edge that zeroes the last register
  // returns to IDLE, giving NUM_REGS-1 cycles in CLEAR.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_reg <= ST_IDLE;
      ptr_reg   <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (clr_req_i) begin
            state_reg <= ST_CLEAR;
            ptr_reg   <= FIRST_IDX;
          end
        end
        default: begin
          if (ptr_reg == LAST_IDX) begin
            state_reg <= ST_IDLE;
          end
          ptr_reg <= ptr_reg + FIRST_IDX;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Register and busy storage. Each register is a separate slice so the whole
  // file can be reset asynchronously; slices publish into reg_val/busy_vec.
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0]   reg_val [NUM_REGS];
  logic [NUM_REGS-1:0] busy_vec;

  assign reg_val[0]  = '0;
  assign busy_vec[0] = 1'b0;

  genvar gi;
  generate
    for (gi = 1; gi < NUM_REGS; gi++) begin : g_reg
      logic [DATA_W-1:0] data_reg;
      logic              busy_reg;
      logic              hit_a;
      logic              hit_b;
      logic              hit_iss;
      logic              hit_clr;

      assign hit_a   = wa_en  & (wa_addr_i  == ADDR_W'(gi));
      assign hit_b   = wb_en  & (wb_addr_i  == ADDR_W'(gi));
      assign hit_iss = iss_en & (iss_addr_i == ADDR_W'(gi));
      assign hit_clr = ~idle  & (ptr_reg    == ADDR_W'(gi));

      always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
          data_reg <= '0;
        end else if (hit_clr) begin
          data_reg <= '0;
        end else if (hit_b) begin
          data_reg <= wb_data_i;
        end else if (hit_a) begin
          data_reg <= wa_data_i;
        end
      end

      // Issue outranks a same-cycle write: the new producer is still pending.
      // Starting a clear flushes every busy bit, including a same-cycle issue.
      always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
          busy_reg <= 1'b0;
        end else if (clr_start) begin
          busy_reg <= 1'b0;
        end else if (hit_iss) begin
          busy_reg <= 1'b1;
        end else if (hit_a | hit_b) begin
          busy_reg <= 1'b0;
        end
      end

      assign reg_val[gi]  = data_reg;
      assign busy_vec[gi] = busy_reg;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Read ports: B bypass, then A bypass, then stored value. The write strobes
  // already exclude x0 and CLEAR, so no extra gating is needed for data. A
  // register being written this cycle no longer has a pending producer, so its
  // busy flag is masked; an issue only shows up after the edge.
  // ---------------------------------------------------------------------------
  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [ADDR_W-1:0] idx;
      logic              fwd_a;
      logic              fwd_b;

      assign idx   = rd_addr_i[gi*ADDR_W +: ADDR_W];
      assign fwd_a = wa_en & (wa_addr_i == idx);
      assign fwd_b = wb_en & (wb_addr_i == idx);

      assign rd_data_o[gi*DATA_W +: DATA_W] = fwd_b ? wb_data_i :
                                              fwd_a ? wa_data_i :
                                                      reg_val[idx];
      assign rd_busy_o[gi] = idle & busy_vec[idx] & ~(fwd_a | fwd_b);
    end
  endgenerate

endmodule

// File: tb/tb_xreg_sb.sv
module tb_xreg_sb;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int NREGS = 32;

  logic            clk;
  logic            rst_n;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data;
  logic [NR-1:0]   rd_busy;
  logic            wa_vld, wb_vld, iss_vld, clr_req;
  logic [AW-1:0]   wa_addr, wb_addr, iss_addr;
  logic [DW-1:0]   wa_data, wb_data;
  logic            clr_busy;

  int passed = 0;
  int total  = 0;

  xreg_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .rd_addr_i  (rd_addr),
    .rd_data_o  (rd_data),
    .rd_busy_o  (rd_busy),
    .wa_vld_i   (wa_vld),
    .wa_addr_i  (wa_addr),
    .wa_data_i  (wa_data),
    .wb_vld_i   (wb_vld),
    .wb_addr_i  (wb_addr),
    .wb_data_i  (wb_data),
    .iss_vld_i  (iss_vld),
    .iss_addr_i (iss_addr),
    .clr_req_i  (clr_req),
    .clr_busy_o (clr_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: register contents, pending-producer flags, and the clear
  // sequence as "next register to zero" plus an in-progress flag.
  logic [DW-1:0] m_regs [NREGS];
  bit            m_busy [NREGS];
  bit            m_clr;
  int            m_next;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NREGS; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
    m_clr  = 1'b0;
    m_next = 0;
  endfunction

  function automatic bit wr_hit_a(input logic [AW-1:0] a);
    return !m_clr && wa_vld && (wa_addr != 0) && (wa_addr == a);
  endfunction

  function automatic bit wr_hit_b(input logic [AW-1:0] a);
    return !m_clr && wb_vld && (wb_addr != 0) && (wb_addr == a);
  endfunction

  function automatic logic [DW-1:0] exp_data(input logic [AW-1:0] a);
    if (wr_hit_b(a)) return wb_data;
    if (wr_hit_a(a)) return wa_data;
    return m_regs[a];
  endfunction

  function automatic logic exp_busy(input logic [AW-1:0] a);
    if (m_clr) return 1'b0;
    if (wr_hit_a(a) || wr_hit_b(a)) return 1'b0;
    return m_busy[a];
  endfunction

  // Apply the effect of one rising edge given the inputs present at that edge.
  function automatic void model_edge();
    if (!m_clr) begin
      if (wa_vld && wa_addr != 0) begin
        m_regs[wa_addr] = wa_data;
        m_busy[wa_addr] = 1'b0;
      end
      if (wb_vld && wb_addr != 0) begin
        m_regs[wb_addr] = wb_data;
        m_busy[wb_addr] = 1'b0;
      end
      if (clr_req) begin
        for (int i = 0; i < NREGS; i++) m_busy[i] = 1'b0;
        m_clr  = 1'b1;
        m_next = 1;
      end else if (iss_vld && iss_addr != 0) begin
        m_busy[iss_addr] = 1'b1;
      end
    end else begin
      m_regs[m_next] = '0;
      m_next++;
      if (m_next == NREGS) m_clr = 1'b0;
    end
  endfunction

  task automatic check_outputs();
    for (int k = 0; k < NR; k++) begin
      logic [AW-1:0] a;
      a = rd_addr[k*AW +: AW];
      chk($sformatf("rd%0d_data x%0d", k, a), 64'(rd_data[k*DW +: DW]), 64'(exp_data(a)));
      chk($sformatf("rd%0d_busy x%0d", k, a), 64'(rd_busy[k]), 64'(exp_busy(a)));
    end
    chk("clr_busy", 64'(clr_busy), 64'(m_clr));
  endtask

  // Inputs are driven at posedge+1; outputs are checked at the falling edge.
  task automatic half();
    #4;
    check_outputs();
  endtask

  task automatic rest();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic cycle();
    half();
    rest();
  endtask

  task automatic quiet();
    wa_vld = 0; wb_vld = 0; iss_vld = 0; clr_req = 0;
    wa_addr = '0; wb_addr = '0; iss_addr = '0;
    wa_data = '0; wb_data = '0;
  endtask

  task automatic rd2(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    rd_addr = {a1, a0};
  endtask

  task automatic sweep();
    quiet();
    for (int i = 0; i < NREGS; i++) begin
      rd2(AW'(i), AW'(NREGS - 1 - i));
      cycle();
    end
  endtask

  task automatic fill();
    for (int i = 1; i < NREGS; i++) begin
      quiet();
      wa_vld = 1; wa_addr = AW'(i); wa_data = 32'h0101_0101 * i;
      iss_vld = (i % 3 == 0); iss_addr = AW'(i + 1);
      rd2(AW'(i), AW'(i - 1));
      cycle();
    end
    quiet();
  endtask

  initial begin
    int n;
    quiet();
    rd_addr = '0;
    rst_n = 1'b0;
    model_reset();

    // 1. reset state
    #2;
    rd2(5'd5, 5'd31);
    check_outputs();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle();

    // 2. write A with same-cycle bypass, then stored value
    quiet();
    wa_vld = 1; wa_addr = 5'd5; wa_data = 32'h1234;
    rd2(5'd5, 5'd0);
    half(); chk("t2_bypass", 64'(rd_data[31:0]), 64'h1234); rest();
    quiet();
    half(); chk("t2_stored", 64'(rd_data[31:0]), 64'h1234); rest();

    // 3. A and B collide on x7: B wins
    wa_vld = 1; wa_addr = 5'd7; wa_data = 32'hAAAA;
    wb_vld = 1; wb_addr = 5'd7; wb_data = 32'h5555;
    rd2(5'd7, 5'd7);
    half(); chk("t3_bypass", 64'(rd_data[63:32]), 64'h5555); rest();
    quiet();
    half(); chk("t3_stored", 64'(rd_data[31:0]), 64'h5555); rest();

    // 4. scoreboard on x3
    iss_vld = 1; iss_addr = 5'd3;
    rd2(5'd3, 5'd3);
    half(); chk("t4_iss_same", 64'(rd_busy[0]), 64'd0); rest();
    quiet();
    half(); chk("t4_busy", 64'(rd_busy[0]), 64'd1); rest();
    wb_vld = 1; wb_addr = 5'd3; wb_data = 32'h9;
    half(); chk("t4_wr_busy", 64'(rd_busy[1]), 64'd0);
    chk("t4_wr_data", 64'(rd_data[31:0]), 64'h9); rest();
    quiet();
    half(); chk("t4_after_wr", 64'(rd_busy[0]), 64'd0); rest();
    iss_vld = 1; iss_addr = 5'd3; wa_vld = 1; wa_addr = 5'd3; wa_data = 32'h77;
    cycle();
    quiet();
    half(); chk("t4_iss_wr_busy", 64'(rd_busy[0]), 64'd1);
    chk("t4_iss_wr_data", 64'(rd_data[31:0]), 64'h77); rest();

    // 5. x0 is immutable and never busy
    wa_vld = 1; wa_addr = 5'd0; wa_data = 32'hFFFF;
    wb_vld = 1; wb_addr = 5'd0; wb_data = 32'hFFFF;
    iss_vld = 1; iss_addr = 5'd0;
    rd2(5'd0, 5'd0);
    half(); chk("t5_x0_bypass", 64'(rd_data[31:0]), 64'd0); rest();
    quiet();
    half(); chk("t5_x0_data", 64'(rd_data[31:0]), 64'd0);
    chk("t5_x0_busy", 64'(rd_busy[0]), 64'd0); rest();

    // 6a. full clear with a write attempt to x4 during the window
    fill();
    clr_req = 1; rd2(5'd4, 5'd9);
    cycle();
    quiet();
    n = 0;
    while (clr_busy === 1'b1 && n < 100) begin
      wa_vld = 1; wa_addr = 5'd4; wa_data = 32'hDEAD_BEEF;
      iss_vld = 1; iss_addr = 5'd4;
      clr_req = (n % 2 == 0);
      rd2(5'd4, AW'($urandom_range(0, NREGS - 1)));
      cycle();
      n++;
    end
    chk("t6_clear_cycles", 64'(n), 64'd31);
    sweep();

    // 6b. reset asserted in the middle of a clear
    fill();
    clr_req = 1; cycle();
    quiet();
    for (int i = 0; i < 10; i++) begin
      rd2(AW'($urandom_range(0, NREGS - 1)), AW'($urandom_range(0, NREGS - 1)));
      cycle();
    end
    rst_n = 1'b0;
    model_reset();
    rd2(5'd20, 5'd31);
    #2;
    chk("t6_rst_clr_busy", 64'(clr_busy), 64'd0);
    check_outputs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    sweep();

    // 7. randomized traffic against the model
    for (int t = 0; t < 400; t++) begin
      bit narrow;
      narrow  = ($urandom_range(0, 1) == 1);
      wa_vld  = ($urandom_range(0, 1) == 1);
      wb_vld  = ($urandom_range(0, 3) == 0);
      iss_vld = ($urandom_range(0, 2) == 0);
      clr_req = ($urandom_range(0, 79) == 0);
      wa_addr  = narrow ? AW'($urandom_range(0, 7)) : AW'($urandom);
      wb_addr  = narrow ? AW'($urandom_range(0, 7)) : AW'($urandom);
      iss_addr = narrow ? AW'($urandom_range(0, 7)) : AW'($urandom);
      wa_data  = $urandom;
      wb_data  = $urandom;
      rd2(narrow ? AW'($urandom_range(0, 7)) : AW'($urandom),
          narrow ? AW'($urandom_range(0, 7)) : AW'($urandom));
      cycle();
    end
    sweep();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
